// File: rtl/test_port_capture.sv
// -----------------------------------------------------------------------------
// test_port_capture
//   Watches CPU data-memory writes to the simulation test port, byte-swaps them
//   into readable order, frames them from BEGIN_SYM to END_SYM (inclusive) and
//   queues them in a fall-through valid/ready FIFO for the result checker.
//   A wen pulse of any length produces at most one capture (its first cycle),
//   so D-cache stalls never duplicate words.
//
// Ports
//   clk         in   system clock, all logic on posedge
//   rst         in   asynchronous, active-high reset
//   mem_addr    in   [29:0] CPU data-memory word address
//   mem_wdata   in   [31:0] CPU write data, little-endian
//   mem_wen     in   CPU write enable (may be held high across a stall)
//   out_valid   out  FIFO head holds a word
//   out_ready   in   downstream accepts the head word this cycle
//   out_data    out  [31:0] head word, readable byte order (0 when empty)
//   out_last    out  head word is END_SYM (0 when empty)
//   capturing   out  FSM is in CAPTURE
//   word_count  out  [CNT_W-1:0] accepted pushes, saturating
//   overflow    out  sticky: a word was dropped on a full FIFO
//   done        out  END_SYM handled and FIFO drained
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a BEGIN_SYM write; other writes discarded
// CAPTURE | every write pushed; END_SYM write moves on to DRAIN
// DRAIN   | writes ignored; waiting for the FIFO to empty
// DONE    | stream complete; done held until reset
// -----------------------------------------------------------------------------
module test_port_capture #(
   parameter logic [29:0] TEST_ADDR = 30'h10,
   parameter logic [31:0] BEGIN_SYM = 32'h0000_0168,
   parameter logic [31:0] END_SYM   = 32'hFFFF_FD5D,
   parameter int          DEPTH     = 8,
   parameter int          CNT_W     = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [29:0]      mem_addr,
   input  logic [31:0]      mem_wdata,
   input  logic             mem_wen,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic             out_last,
   output logic             capturing,
   output logic [CNT_W-1:0] word_count,
   output logic             overflow,
   output logic             done
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CAPTURE = 2'd1;
   localparam logic [1:0] ST_DRAIN   = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   logic [1:0]       state_q, state_d;
   logic             arm_q, arm_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [32:0]      mem_q [DEPTH];
   logic [32:0]      mem_d [DEPTH];
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;

   logic [31:0]      swapped;
   logic             wr_event;
   logic             fifo_empty;
   logic             fifo_full;
   logic             pop;
   logic             push;
   logic             push_last;
   logic             accept;
   logic [32:0]      head;

   assign swapped    = {mem_wdata[7:0], mem_wdata[15:8], mem_wdata[23:16], mem_wdata[31:24]};
   assign wr_event   = mem_wen && arm_q && (mem_addr == TEST_ADDR);

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign pop        = !fifo_empty && out_ready;
   // A full FIFO still takes the word when the head leaves in the same cycle.
   assign accept     = push && (!fifo_full || pop);

   always_comb begin
      state_d   = state_q;
      push      = 1'b0;
      push_last = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (wr_event && (swapped == BEGIN_SYM)) begin
               push    = 1'b1;
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (wr_event) begin
               push = 1'b1;
               // The FSM advances even if this END word gets dropped.
               if (swapped == END_SYM) begin
                  push_last = 1'b1;
                  state_d   = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (fifo_empty) state_d = ST_DONE;
         end
         default: state_d = ST_DONE;
      endcase
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (accept) begin
         mem_d[wr_ptr_q[AW-1:0]] = {push_last, swapped};
         wr_ptr_d                = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
   end

   always_comb begin
      count_d = count_q;
      if (accept && (count_q != {CNT_W{1'b1}})) count_d = count_q + CNT_W'(1);
      ovf_d = ovf_q | (push && !accept);
      // Re-arms on the first idle cycle, so one pulse gives at most one event.
      arm_d = !mem_wen;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         arm_q    <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         arm_q    <= arm_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         mem_q    <= mem_d;
      end
   end

   assign head       = mem_q[rd_ptr_q[AW-1:0]];
   assign out_valid  = !fifo_empty;
   assign out_data   = fifo_empty ? 32'h0 : head[31:0];
   assign out_last   = fifo_empty ? 1'b0 : head[32];
   assign capturing  = (state_q == ST_CAPTURE);
   assign done       = (state_q == ST_DONE);
   assign word_count = count_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_test_port_capture.sv
module tb_test_port_capture;

   localparam logic [29:0] TEST_ADDR = 30'h10;
   localparam logic [31:0] BEGIN_SYM = 32'h0000_0168;
   localparam logic [31:0] END_SYM   = 32'hFFFF_FD5D;
   localparam int          DEPTH     = 8;
   localparam int          CNT_W     = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [29:0]      mem_addr = '0;
   logic [31:0]      mem_wdata = '0;
   logic             mem_wen = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [31:0]      out_data;
   logic             out_last;
   logic             capturing;
   logic [CNT_W-1:0] word_count;
   logic             overflow;
   logic             done;

   test_port_capture #(
      .TEST_ADDR(TEST_ADDR), .BEGIN_SYM(BEGIN_SYM), .END_SYM(END_SYM),
      .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wen(mem_wen), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .capturing(capturing),
      .word_count(word_count), .overflow(overflow), .done(done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] bswap(input logic [31:0] x);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = x[8*(3-b) +: 8];
      return r;
   endfunction

   // ---------------- reference model ----------------
   localparam int M_IDLE = 0, M_CAP = 1, M_DRAIN = 2, M_DONE = 3;
   logic [32:0] mq[$];
   int          m_state;
   bit          m_arm;
   int          m_count;
   bit          m_ovf;

   task automatic model_reset();
      mq.delete();
      m_state = M_IDLE;
      m_arm   = 1'b1;
      m_count = 0;
      m_ovf   = 1'b0;
   endtask

   task automatic model_edge(input logic [29:0] a, input logic [31:0] d, input logic w, input logic r);
      bit          ev;
      bit          pop_now;
      bit          push_now;
      bit          lst;
      bit          was_empty;
      logic [31:0] s;
      s         = bswap(d);
      ev        = w && m_arm && (a == TEST_ADDR);
      was_empty = (mq.size() == 0);
      pop_now   = !was_empty && r;
      push_now  = 1'b0;
      lst       = 1'b0;
      case (m_state)
         M_IDLE:  if (ev && s == BEGIN_SYM) begin push_now = 1'b1; m_state = M_CAP; end
         M_CAP:   if (ev) begin
                     push_now = 1'b1;
                     if (s == END_SYM) begin lst = 1'b1; m_state = M_DRAIN; end
                  end
         M_DRAIN: if (was_empty) m_state = M_DONE;
         default: ;
      endcase
      if (pop_now) void'(mq.pop_front());
      if (push_now) begin
         if (mq.size() < DEPTH) begin
            mq.push_back({lst, s});
            if (m_count < (1 << CNT_W) - 1) m_count++;
         end else begin
            m_ovf = 1'b1;
         end
      end
      m_arm = !w;
   endtask

   task automatic compare_model();
      chk("m_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
         chk("m_data", out_data, mq[0][31:0]);
         chk("m_last", 32'(out_last), 32'(mq[0][32]));
      end
      chk("m_capturing", 32'(capturing), 32'(m_state == M_CAP));
      chk("m_count", 32'(word_count), 32'(m_count));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_done", 32'(done), 32'(m_state == M_DONE));
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic step(input logic [29:0] a, input logic [31:0] d, input logic w, input logic r);
      mem_addr  = a;
      mem_wdata = d;
      mem_wen   = w;
      out_ready = r;
      @(posedge clk);
      model_edge(a, d, w, r);
      #1;
      compare_model();
   endtask

   task automatic write_word(input logic [31:0] readable, input logic r);
      step(TEST_ADDR, bswap(readable), 1'b1, r);
      step(TEST_ADDR, bswap(readable), 1'b0, r);
   endtask

   // Asserts reset between edges and checks outputs clear without a clock edge.
   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk("rst_capturing", 32'(capturing), 32'd0);
      chk("rst_count", 32'(word_count), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic drain_collect(output logic [31:0] got[$]);
      got.delete();
      for (int i = 0; i < 2 * DEPTH + 4; i++) begin
         if (out_valid) got.push_back(out_data);
         step(TEST_ADDR, 32'h0, 1'b0, 1'b1);
      end
   endtask

   typedef struct {
      logic             wen;
      logic [31:0]      wdata;
      logic             exp_valid;
      logic [31:0]      exp_data;
      logic             exp_last;
      logic             exp_cap;
      logic [CNT_W-1:0] exp_count;
      logic             exp_done;
   } vec_t;

   vec_t        tbl[7];
   logic [31:0] got[$];
   logic [31:0] exp_list[$];

   initial begin #2_000_000; $display("FAIL watchdog: simulation time limit"); $fatal(1); end

   initial begin
      tbl[0] = '{1'b1, 32'h6801_0000, 1'b1, 32'h0000_0168, 1'b0, 1'b1, 5'd1, 1'b0};
      tbl[1] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 5'd1, 1'b0};
      tbl[2] = '{1'b1, 32'hCCCC_0000, 1'b1, 32'h0000_CCCC, 1'b0, 1'b1, 5'd2, 1'b0};
      tbl[3] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 5'd2, 1'b0};
      tbl[4] = '{1'b1, 32'h5DFD_FFFF, 1'b1, 32'hFFFF_FD5D, 1'b1, 1'b0, 5'd3, 1'b0};
      tbl[5] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 5'd3, 1'b0};
      tbl[6] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 5'd3, 1'b1};

      model_reset();
      do_reset();

      // 1: basic framed stream
      for (int i = 0; i < 7; i++) begin
         step(TEST_ADDR, tbl[i].wdata, tbl[i].wen, 1'b1);
         chk($sformatf("t1_valid[%0d]", i), 32'(out_valid), 32'(tbl[i].exp_valid));
         if (tbl[i].exp_valid) begin
            chk($sformatf("t1_data[%0d]", i), out_data, tbl[i].exp_data);
            chk($sformatf("t1_last[%0d]", i), 32'(out_last), 32'(tbl[i].exp_last));
         end
         chk($sformatf("t1_cap[%0d]", i), 32'(capturing), 32'(tbl[i].exp_cap));
         chk($sformatf("t1_count[%0d]", i), 32'(word_count), 32'(tbl[i].exp_count));
         chk($sformatf("t1_done[%0d]", i), 32'(done), 32'(tbl[i].exp_done));
      end

      // 2: stalled wen held 4 cycles counts once
      do_reset();
      write_word(BEGIN_SYM, 1'b0);
      for (int i = 0; i < 4; i++) step(TEST_ADDR, 32'h6387_0000, 1'b1, 1'b0);
      step(TEST_ADDR, 32'h0, 1'b0, 1'b0);
      chk("t2_count", 32'(word_count), 32'd2);
      drain_collect(got);
      chk("t2_n", got.size(), 32'd2);
      if (got.size() == 2) chk("t2_word", got[1], 32'h0000_8763);

      // 3: wrong address and BEGIN-less data in IDLE
      do_reset();
      step(30'h11, bswap(BEGIN_SYM), 1'b1, 1'b1);
      step(30'h11, bswap(BEGIN_SYM), 1'b0, 1'b1);
      chk("t3_valid_a", 32'(out_valid), 32'd0);
      chk("t3_cap_a", 32'(capturing), 32'd0);
      write_word(32'h1234_5678, 1'b1);
      chk("t3_valid_b", 32'(out_valid), 32'd0);
      chk("t3_cap_b", 32'(capturing), 32'd0);
      chk("t3_count", 32'(word_count), 32'd0);

      // 4: overflow with out_ready low
      do_reset();
      write_word(BEGIN_SYM, 1'b0);
      for (int i = 0; i < DEPTH; i++) write_word(32'hA0 + i, 1'b0);
      chk("t4_overflow", 32'(overflow), 32'd1);
      chk("t4_count", 32'(word_count), 32'(DEPTH));
      drain_collect(got);
      exp_list.delete();
      exp_list.push_back(BEGIN_SYM);
      for (int i = 0; i < DEPTH - 1; i++) exp_list.push_back(32'hA0 + i);
      chk("t4_n", got.size(), exp_list.size());
      for (int i = 0; i < got.size() && i < exp_list.size(); i++)
         chk($sformatf("t4_word[%0d]", i), got[i], exp_list[i]);

      // 5: full FIFO, push and pop in the same cycle
      do_reset();
      write_word(BEGIN_SYM, 1'b0);
      for (int i = 0; i < DEPTH - 1; i++) write_word(32'hB0 + i, 1'b0);
      step(TEST_ADDR, bswap(32'hB0 + DEPTH - 1), 1'b1, 1'b1);
      step(TEST_ADDR, 32'h0, 1'b0, 1'b0);
      chk("t5_overflow", 32'(overflow), 32'd0);
      chk("t5_count", 32'(word_count), 32'(DEPTH + 1));
      drain_collect(got);
      chk("t5_n", got.size(), 32'(DEPTH));
      for (int i = 0; i < got.size() && i < DEPTH; i++)
         chk($sformatf("t5_word[%0d]", i), got[i], 32'hB0 + i);

      // 6: reset mid-capture; wen already high at release is captured once
      do_reset();
      write_word(BEGIN_SYM, 1'b0);
      write_word(32'h11, 1'b0);
      write_word(32'h22, 1'b0);
      mem_addr  = TEST_ADDR;
      mem_wdata = bswap(BEGIN_SYM);
      mem_wen   = 1'b1;
      do_reset();
      for (int i = 0; i < 3; i++) step(TEST_ADDR, bswap(BEGIN_SYM), 1'b1, 1'b0);
      chk("t6_count", 32'(word_count), 32'd1);
      chk("t6_cap", 32'(capturing), 32'd1);
      chk("t6_head", out_data, BEGIN_SYM);
      step(TEST_ADDR, 32'h0, 1'b0, 1'b1);

      // random phase against the model
      begin
         logic        w;
         logic [29:0] a;
         logic [31:0] d;
         logic        r;
         int          k;
         w = 1'b0;
         do_reset();
         for (int i = 0; i < 1200; i++) begin
            if (i % 100 == 99) do_reset();
            a = ($urandom_range(0, 7) == 0) ? 30'h11 : TEST_ADDR;
            r = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) w = ~w;
            k = $urandom_range(0, 24);
            d = (k < 3) ? bswap(BEGIN_SYM) : (k == 3) ? bswap(END_SYM) : $urandom;
            step(a, d, w, r);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
